// File: rtl/brd_io_gen_pkg.sv
// Shared constants for the board-I/O peripheral: register map, poll reply
// and the width of the clock-tick pulse array (`MXCLK).
// Build option BRD_DEBOUNCE_EN (used by brd_debounce) selects the tick-based
// debouncer; without it each button state simply follows its synchroniser.
`ifndef MXCLK
`define MXCLK 7
`endif

package brd_io_gen_pkg;

    localparam logic [7:0] BRD_REG_STATE  = 8'd0;
    localparam logic [7:0] BRD_REG_CHG    = 8'd1;
    localparam logic [7:0] BRD_REG_LED    = 8'd2;
    localparam logic [7:0] BRD_REG_IEN    = 8'd3;
    localparam logic [7:0] BRD_REG_ID     = 8'd64;

    localparam logic [7:0] BRD_POLL_READY = 8'h02;

    // The ID window is 64..95: address bits [7:5] == 3'b010.
    function automatic logic brd_is_id(input logic [7:0] adr);
        return adr[7:5] == BRD_REG_ID[7:5];
    endfunction

endpackage

// File: rtl/brd_io_gen_debounce.sv
// One button: two-flop synchroniser followed by either a tick-counted
// debouncer (BRD_DEBOUNCE_EN defined) or a plain follower (undefined).
// change_o pulses in the cycle whose clock edge updates state_o.
module brd_debounce
    import brd_io_gen_pkg::*;
#(
    parameter int DB_TICKS = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic pin_i,
    output logic state_o,
    output logic change_o
);

    logic sync1_q, sync2_q;
    logic state_q, state_d;
    logic accept;

    // Synchroniser and accepted-state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
        end
    end

`ifdef BRD_DEBOUNCE_EN
    localparam int CW = $clog2(DB_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count ticks on which the input disagrees with the state; accept on the DB_TICKS-th.
    always_comb begin
        cnt_d  = cnt_q;
        accept = 1'b0;
        if (tick_i) begin
            if (sync2_q != state_q) begin
                if (cnt_q == CNT_LAST) begin
                    accept = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    // Debounce counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    localparam int unused_db_ticks = DB_TICKS;
    logic unused_tick;
    assign unused_tick = tick_i;

    // State follows the synchroniser every cycle; any difference is a change.
    always_comb begin
        accept = (sync2_q != state_q);
    end
`endif

    assign state_d  = accept ? sync2_q : state_q;
    assign state_o  = state_q;
    assign change_o = accept;

endmodule

// File: rtl/brd_io_gen.sv
// Board-I/O peripheral on the Peripheral Controller bus: debounced buttons
// with sticky change latching, LED register, poll-driven event reporting and
// a window onto the external peripheral ID table. Answers ADR_I[7]==0.
// Build option BRD_DEBOUNCE_EN enables the tick-based debouncer in brd_debounce.
module brd_io_gen
    import brd_io_gen_pkg::*;
#(
    parameter int NBTN     = 2,
    parameter int NLED     = 4,
    parameter bit BTN_INV  = 1'b0,
    parameter int TICK_IDX = 4,
    parameter int DB_TICKS = 8
) (
    input  logic                       CLK_I,
    input  logic                       RST_I,
    input  logic                       WE_I,
    input  logic                       TGA_I,
    input  logic                       STB_I,
    input  logic [7:0]                 ADR_I,
    output logic                       STALL_O,
    output logic                       ACK_O,
    input  logic [7:0]                 DAT_I,
    output logic [7:0]                 DAT_O,
    input  logic [`MXCLK:0]            clocks,
    input  logic [NBTN-1:0]            btn,
    output logic [(NLED>0?NLED:1)-1:0] led,
    output logic [3:0]                 perid_idx,
    input  logic [15:0]                perid
);

    logic            myaddr, reg_rd, reg_wr, rd_chg;
    logic            tick, unused_clocks;
    logic [NBTN-1:0] state, change;
    logic [NBTN-1:0] chg_q, chg_d, ien_q, ien_d;
    logic            dr_q, dr_d;
    logic [7:0]      led8;

    assign myaddr    = STB_I & ~ADR_I[7];
    assign ACK_O     = myaddr;
    assign STALL_O   = 1'b0;
    assign reg_rd    = myaddr & TGA_I & ~WE_I;
    assign reg_wr    = myaddr & TGA_I & WE_I;
    assign rd_chg    = reg_rd & (ADR_I == BRD_REG_CHG);
    assign perid_idx = ADR_I[4:1];
    assign tick      = clocks[TICK_IDX];
    assign unused_clocks = ^clocks;

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        brd_debounce #(.DB_TICKS(DB_TICKS)) u_db (
            .clk_i    (CLK_I),
            .rst_i    (RST_I),
            .tick_i   (tick),
            .pin_i    (btn[i] ^ BTN_INV),
            .state_o  (state[i]),
            .change_o (change[i])
        );
    end

    // Sticky change mask, event flag and enable mask; a new event beats a clearing read.
    always_comb begin
        chg_d = (rd_chg ? '0 : chg_q) | change;
        dr_d  = dr_q;
        if (rd_chg) dr_d = 1'b0;
        if (|(change & ien_q)) dr_d = 1'b1;
        ien_d = ien_q;
        if (reg_wr && ADR_I == BRD_REG_IEN) ien_d = DAT_I[NBTN-1:0];
    end

    // Event and enable registers.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            chg_q <= '0;
            dr_q  <= 1'b0;
            ien_q <= '1;
        end else begin
            chg_q <= chg_d;
            dr_q  <= dr_d;
            ien_q <= ien_d;
        end
    end

    if (NLED > 0) begin : g_led
        logic [NLED-1:0] led_q, led_d;

        // LED register next value.
        always_comb begin
            led_d = led_q;
            if (reg_wr && ADR_I == BRD_REG_LED) led_d = DAT_I[NLED-1:0];
        end

        // LED register.
        always_ff @(posedge CLK_I) begin
            if (RST_I) led_q <= '0;
            else       led_q <= led_d;
        end

        assign led  = led_q;
        assign led8 = 8'(led_q);
    end else begin : g_no_led
        assign led  = 1'b0;
        assign led8 = 8'h00;
    end

    // Read mux; unaddressed cycles pass the bus data through.
    always_comb begin
        DAT_O = DAT_I;
        if (myaddr) begin
            DAT_O = 8'h00;
            if (!TGA_I) begin
                DAT_O = dr_q ? BRD_POLL_READY : 8'h00;
            end else if (brd_is_id(ADR_I)) begin
                DAT_O = ADR_I[0] ? perid[7:0] : perid[15:8];
            end else begin
                case (ADR_I)
                    BRD_REG_STATE: DAT_O = 8'(state);
                    BRD_REG_CHG:   DAT_O = 8'(chg_q);
                    BRD_REG_LED:   DAT_O = led8;
                    BRD_REG_IEN:   DAT_O = 8'(ien_q);
                    default:       DAT_O = 8'h00;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_brd_io_gen.sv
// Self-checking bench for brd_io_gen with a behavioural model and directed vectors.
`ifndef MXCLK
`define MXCLK 7
`endif

module tb_brd_io_gen;

    localparam int NBTN = 2;
    localparam int NLED = 4;
    localparam bit INV  = 1'b0;
    localparam int TICK = 4;
    localparam int DB   = 8;
    localparam int TPER = 4;
`ifdef BRD_DEBOUNCE_EN
    localparam int ACCEPT_TICKS = DB;
    localparam int PRE_EDGES    = 4 * DB - 2;
`else
    localparam int ACCEPT_TICKS = 0;
    localparam int PRE_EDGES    = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, we, tga, stb;
    logic [7:0] adr, dat_i, dat_o;
    logic stall, ack;
    logic [`MXCLK:0] clocks;
    logic [NBTN-1:0] btn;
    logic [NLED-1:0] led;
    logic [3:0] perid_idx;
    logic [15:0] perid;
    logic [15:0] id_tab [16];

    assign perid = id_tab[perid_idx];

    brd_io_gen #(.NBTN(NBTN), .NLED(NLED), .BTN_INV(INV), .TICK_IDX(TICK), .DB_TICKS(DB)) dut (
        .CLK_I(clk), .RST_I(rst), .WE_I(we), .TGA_I(tga), .STB_I(stb), .ADR_I(adr),
        .STALL_O(stall), .ACK_O(ack), .DAT_I(dat_i), .DAT_O(dat_o), .clocks(clocks),
        .btn(btn), .led(led), .perid_idx(perid_idx), .perid(perid)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Debounce sample tick: one-cycle pulse every TPER cycles.
    int tcnt = 0;
    initial begin
        clocks = '0;
        forever begin
            @(posedge clk); #1;
            tcnt++;
            clocks[TICK] = (tcnt % TPER == 0);
        end
    end

    // Behavioural model: each button's level reaches the debouncer two cycles
    // after the pin; it is accepted after DB consecutive disagreeing ticks.
    logic [NBTN-1:0] m_p1, m_p2, m_st, m_chg, m_ien;
    int              m_run [NBTN];
    logic            m_dr;
    logic [NLED-1:0] m_led;

    always @(posedge clk) begin : model
        logic [NBTN-1:0] nb;
        logic rd1;
        if (rst) begin
            m_p1 = '0; m_p2 = '0; m_st = '0; m_chg = '0; m_ien = '1;
            m_dr = 1'b0; m_led = '0;
            for (int i = 0; i < NBTN; i++) m_run[i] = 0;
        end else begin
            rd1 = stb && !adr[7] && tga && !we && adr == 8'd1;
            nb  = '0;
            for (int i = 0; i < NBTN; i++) begin
`ifdef BRD_DEBOUNCE_EN
                if (clocks[TICK]) begin
                    if (m_p2[i] != m_st[i]) begin
                        m_run[i] = m_run[i] + 1;
                        if (m_run[i] == DB) begin
                            m_st[i] = m_p2[i]; m_run[i] = 0; nb[i] = 1'b1;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
`else
                if (m_p2[i] != m_st[i]) begin
                    m_st[i] = m_p2[i]; nb[i] = 1'b1;
                end
`endif
                m_p2[i] = m_p1[i];
                m_p1[i] = btn[i] ^ INV;
            end
            if (|(nb & m_ien)) m_dr = 1'b1;
            else if (rd1)      m_dr = 1'b0;
            m_chg = (rd1 ? '0 : m_chg) | nb;
            if (stb && !adr[7] && tga && we && adr == 8'd2) m_led = dat_i[NLED-1:0];
            if (stb && !adr[7] && tga && we && adr == 8'd3) m_ien = dat_i[NBTN-1:0];
        end
    end

    function automatic logic [7:0] exp_dat();
        logic [7:0] v;
        v = 8'h00;
        if (!(stb && !adr[7])) return dat_i;
        if (!tga) return m_dr ? 8'h02 : 8'h00;
        if (adr >= 8'd64 && adr <= 8'd95)
            return adr[0] ? id_tab[adr[4:1]][7:0] : id_tab[adr[4:1]][15:8];
        case (adr)
            8'd0: v[NBTN-1:0] = m_st;
            8'd1: v[NBTN-1:0] = m_chg;
            8'd2: v[NLED-1:0] = m_led;
            8'd3: v[NBTN-1:0] = m_ien;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Compare every cycle against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_dat_o", dat_o, exp_dat());
            check("cyc_ack", ack, stb && !adr[7]);
            check("cyc_stall", stall, 0);
            check("cyc_led", led, m_led);
            check("cyc_perid_idx", perid_idx, adr[4:1]);
        end
    end

    task automatic bus(input logic s, input logic t, input logic w,
                       input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        stb = s; tga = t; we = w; adr = a; dat_i = d;
    endtask

    task automatic peek(input string name, input logic [7:0] want);
        @(negedge clk);
        check(name, dat_o, want);
    endtask

    task automatic align_tick();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!clocks[TICK] && k < 20);
        if (k >= 20) check("align_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic measure_ticks(input string name, input logic [7:0] want_state, input int want_ticks);
        int n;
        bit seen;
        n = 0; seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (dat_o == want_state) seen = 1'b1;
            else if (clocks[TICK]) n++;
        end
        check({name, "_reached"}, seen, 1);
        check({name, "_ticks"}, n, want_ticks);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) id_tab[i] = 16'h1234 + 16'(i) * 16'h0101;
        rst = 1'b1; btn = '0;
        stb = 1'b0; tga = 1'b0; we = 1'b0; adr = 8'h00; dat_i = 8'h00;
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        bus(1, 1, 0, 8'd0, 0); peek("rst_state", 8'h00);
        bus(1, 1, 0, 8'd1, 0); peek("rst_chg", 8'h00);
        bus(1, 1, 0, 8'd2, 0); peek("rst_led", 8'h00);
        bus(1, 1, 0, 8'd3, 0); peek("rst_ien", 8'h03);
        bus(1, 0, 0, 8'd0, 0); peek("rst_poll", 8'h00);
        check("rst_ack", ack, 1);

        // Held press of btn[1]
        bus(1, 1, 0, 8'd0, 0);
        align_tick();
        btn[1] = 1'b1;
        measure_ticks("press1", 8'h02, ACCEPT_TICKS);
        bus(1, 0, 0, 8'd0, 0); peek("press1_poll", 8'h02);
        bus(1, 1, 0, 8'd1, 0); peek("press1_chg", 8'h02);
        bus(1, 0, 0, 8'd0, 0); peek("press1_poll_clr", 8'h00);

        // Short glitch on btn[0]
        align_tick();
        btn[0] = 1'b1;
        repeat (5 * TPER) @(posedge clk);
        #1 btn[0] = 1'b0;
        repeat (40) bus(1, 0, 0, 8'd0, 0);
`ifdef BRD_DEBOUNCE_EN
        peek("glitch_poll", 8'h00);
        bus(1, 1, 0, 8'd0, 0); peek("glitch_state", 8'h02);
        bus(1, 1, 0, 8'd1, 0); peek("glitch_chg", 8'h00);
`else
        bus(1, 1, 0, 8'd1, 0); @(negedge clk);
`endif

        // New change lands in the cycle of a reg1 read
        bus(1, 0, 0, 8'd0, 0);
        align_tick();
        btn[0] = 1'b1;
        repeat (PRE_EDGES) bus(1, 0, 0, 8'd0, 0);
        bus(1, 1, 0, 8'd1, 0); peek("same_cyc_chg_old", 8'h00);
        bus(1, 0, 0, 8'd0, 0); peek("same_cyc_poll", 8'h02);
        bus(1, 1, 0, 8'd1, 0); peek("same_cyc_chg", 8'h01);
        bus(1, 0, 0, 8'd0, 0); peek("same_cyc_poll_clr", 8'h00);

        // Enable mask off, release btn[0]; later enable is not retroactive
        bus(1, 1, 1, 8'd3, 8'h00);
        bus(1, 1, 0, 8'd3, 0); peek("ien_zero", 8'h00);
        btn[0] = 1'b0;
        repeat (45) bus(1, 0, 0, 8'd0, 0);
        peek("masked_poll", 8'h00);
        bus(1, 1, 1, 8'd3, 8'hFF);
        bus(1, 0, 0, 8'd0, 0); peek("no_retro_poll", 8'h00);
        bus(1, 1, 0, 8'd3, 0); peek("ien_back", 8'h03);
        bus(1, 1, 0, 8'd1, 0); peek("masked_chg", 8'h01);
        bus(1, 1, 0, 8'd0, 0); peek("released_state", 8'h02);

        // LED register, upper data bits dropped
        bus(1, 1, 1, 8'd2, 8'hFA);
        bus(0, 0, 0, 8'd0, 0);
        @(negedge clk); check("led_pins", led, 4'hA);
        bus(1, 1, 0, 8'd2, 0); peek("led_read", 8'h0A);

        // ID table window and unmapped addresses
        bus(1, 1, 0, 8'd64, 0); peek("id64", 8'h12);
        check("id64_idx", perid_idx, 4'd0);
        bus(1, 1, 0, 8'd65, 0); peek("id65", 8'h34);
        bus(1, 1, 0, 8'd71, 0); peek("id71", 8'h37);
        check("id71_idx", perid_idx, 4'd3);
        bus(1, 1, 1, 8'd4, 8'h55);
        bus(1, 1, 0, 8'd4, 0); peek("unmapped4", 8'h00);
        bus(1, 1, 0, 8'd100, 0); peek("unmapped100", 8'h00);

        // Not addressed: pass-through and no ack
        bus(0, 1, 0, 8'd0, 8'h5A); peek("stb0_dat", 8'h5A);
        check("stb0_ack", ack, 0);
        bus(1, 1, 0, 8'h80, 8'hC3); peek("adr7_dat", 8'hC3);
        check("adr7_ack", ack, 0);

        // Reset mid-debounce with both pins pressed
        bus(1, 1, 0, 8'd0, 0);
        btn[0] = 1'b1;
        repeat (16) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        align_tick();
        rst = 1'b0;
        measure_ticks("rst_reaccept", 8'h03, ACCEPT_TICKS);
        bus(1, 0, 0, 8'd0, 0); peek("rst_reaccept_poll", 8'h02);
        bus(1, 1, 0, 8'd2, 0); peek("rst_led_cleared", 8'h00);

        bus(0, 0, 0, 8'd0, 0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/brd_io_gen.md
# brd_io_gen

Parametrised board-I/O peripheral for the Peripheral Controller bus: NBTN debounced user buttons with per-button change latching, a host-writable LED register of NLED bits, a poll-driven auto-send of button events, and host read access to the 16-entry peripheral ID table. It occupies the board slot, answering addresses with ADR_I[7]==0. It replaces the fixed two-button, undebounced board logic used on earlier cards.

## Interface
- NBTN, 2: number of buttons, 1..8
- NLED, 4: number of LEDs, 0..8; 0 removes the LED register
- BTN_INV, 0: 1 = buttons are active-low on the pins
- TICK_IDX, 4: index into clocks[] of the debounce sample tick (one-cycle pulse)
- DB_TICKS, 8: consecutive stable ticks required to accept a new level, 1..255

Ports:
- CLK_I  in  1  system clock
- RST_I  in  1  reset; synchronous, active-high
- WE_I  in  1  1 = write, 0 = read
- TGA_I  in  1  1 = register access, 0 = poll
- STB_I  in  1  peripheral selected
- ADR_I  in  8  register address
- STALL_O  out  1  always 0
- ACK_O  out  1  1 when STB_I and ADR_I[7]==0
- DAT_I  in  8  bus data in
- DAT_O  out  8  bus data out; equals DAT_I when not addressed
- clocks  in  `MXCLK+1  clock-tick pulse array
- btn  in  NBTN  raw button pins
- led  out  max(NLED,1)  LED drive
- perid_idx  out  4  ADR_I[4:1], to the ID table
- perid  in  16  ID returned for perid_idx

## Operation
- myaddr = STB_I & ~ADR_I[7]; ACK_O = myaddr.
- Register map, TGA_I=1:
  - 0 R: debounced state, zero-extended to 8 bits
  - 1 R: sticky change mask; the read clears data_ready and every bit that was set, except bits newly set in the same cycle, which stay set
  - 2 R/W: LED register, low NLED bits; write takes DAT_I[NLED-1:0]
  - 3 R/W: event enable mask, low NBTN bits
  - 64..95 R: even address = perid[15:8], odd address = perid[7:0]
  - all others: read 8'h00, writes ignored
- Poll (TGA_I=0, myaddr): DAT_O = 8'h02 when data_ready, else 8'h00. The host then reads registers 0 and 1.
- Input path: two-flop synchroniser, then XOR with BTN_INV.
- Debounce, per button:
  - on a tick, if sync != state, increment cnt; otherwise cnt = 0
  - when cnt reaches DB_TICKS-1 on a tick: state <= sync, cnt <= 0, set change bit
- data_ready sets when a change bit sets whose enable bit is 1.
- Set and clear of data_ready in the same cycle: set wins.
- A write to register 3 does not retroactively raise data_ready.
- Reset values: state 0, cnt 0, synchronisers 0, change mask 0, data_ready 0, LED 0, enable all ones.
- Reset mid-debounce discards the count. A pin held pressed is re-accepted DB_TICKS ticks after reset.

## Timing
- DAT_O, ACK_O and STALL_O are combinational from the bus inputs and registers.
- Register writes are visible on the led pins and in reads the next cycle.
- Pin to state latency: 2 cycles, plus DB_TICKS ticks, plus at most 1 tick of phase.
- Change bit and data_ready update in the same cycle as state.
- cnt width is $clog2(DB_TICKS+1). cnt never exceeds DB_TICKS-1.

## Configuration
- BRD_DEBOUNCE_EN defined: debounce as above.
- BRD_DEBOUNCE_EN undefined:
  - no counters; state = synchronised input each cycle
  - change bit sets on any difference between state and its previous value
  - DB_TICKS and TICK_IDX are ignored

## Structure
- Shared package/include holds:
  - register address constants (BRD_REG_STATE=0, _CHG=1, _LED=2, _IEN=3, BRD_REG_ID=64)
  - poll reply constant 8'h02
  - `MXCLK
- Sub-module brd_debounce: one button (synchroniser + counter + state), instantiated NBTN times in a generate loop.
- The ID table is external; only the index/data ports live here.

## Test plan
- Reset; read regs 0,1,2,3 -> 00,00,00, and mask of NBTN ones (0x03 for NBTN=2); poll -> 00.
- Hold btn[1] high 8 ticks, DB_TICKS=8 -> state 0x02 on the 8th tick, not earlier; poll -> 02; read reg1 -> 02; poll -> 00.
- Glitch btn[0] high for 5 ticks, then low -> state stays 00, no change bit, poll 00.
- New change lands in the same cycle as a reg1 read -> that bit stays set, data_ready stays 1.
- Write reg3=0x00, press btn[0] -> reg1 bit0=1, poll 00. Write 0x0A to reg2 (NLED=4) -> led=4'hA next cycle.
- ADR_I=64/65 with perid=16'h1234 -> 12/34, perid_idx=0. STB_I=0 -> DAT_O=DAT_I and ACK_O=0.
